// File: rtl/spi_command_frontend_if.sv
// Bundle of SPI byte-side and FIFO-side signals for spi_command_frontend.
// rx_ready is a one-cycle strobe qualifying rx_word, honoured only while cs is low; no backpressure exists.
interface spi_command_frontend_if #(
    parameter int WORD_SIZE  = 8,
    parameter int CHANNELS   = 1,
    parameter int FREE_WIDTH = 5
);
    logic                           cs;
    logic [WORD_SIZE-1:0]           rx_word;
    logic                           rx_ready;
    logic [WORD_SIZE-1:0]           tx_word;
    logic [CHANNELS*FREE_WIDTH-1:0] fifo_free;
    logic [CHANNELS-1:0]            fifo_write_en;
    logic [WORD_SIZE-1:0]           fifo_data;
    logic [CHANNELS-1:0]            fifo_clear;
    logic                           busy;
    logic [2:0]                     err_flags;
    logic [2:0]                     state_dbg;

    modport slave (
        input  cs, rx_word, rx_ready, fifo_free,
        output tx_word, fifo_write_en, fifo_data, fifo_clear, busy, err_flags, state_dbg
    );

    modport master (
        output cs, rx_word, rx_ready, fifo_free,
        input  tx_word, fifo_write_en, fifo_data, fifo_clear, busy, err_flags, state_dbg
    );
endinterface

// File: rtl/spi_command_frontend.sv
// SPI command front end: decodes opcode/channel bytes, stages whole records and
// bursts them into the selected channel FIFO; replies with free count or error flags.
module spi_command_frontend #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 4,
    parameter int CHANNELS     = 1,
    parameter int FREE_WIDTH   = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    spi_command_frontend_if.slave bus
);
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNTW = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
    localparam int XW   = (FREE_WIDTH > WORD_SIZE) ? FREE_WIDTH : WORD_SIZE;
    localparam logic [CNTW-1:0] LAST = CNTW'(RECORD_WORDS - 1);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_STATUS = 4'h1;
    localparam logic [3:0] OP_WRITE  = 4'h2;
    localparam logic [3:0] OP_CLEAR  = 4'h3;
    localparam logic [3:0] OP_ERRS   = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_COLLECT = 3'd2,
        S_DRAIN   = 3'd3,
        S_SINK    = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CNTW-1:0]      cnt, cnt_n;
    logic [CHW-1:0]       sel_ch, sel_n;
    logic [2:0]           flags, flag_set;
    logic                 flag_clr;
    logic [CHANNELS-1:0]  clear_q, clear_n;
    logic [WORD_SIZE-1:0] tx_q;
    logic                 tx_load, tx_errs, buf_we;
    logic [WORD_SIZE-1:0] rec_buf [RECORD_WORDS];

    logic           rx_v;
    logic [3:0]     cmd_op, cmd_ch;
    logic [CHW-1:0] cmd_idx;
    logic           cmd_bad;

    assign rx_v    = bus.rx_ready & ~bus.cs;
    assign cmd_op  = bus.rx_word[3:0];
    assign cmd_ch  = bus.rx_word[7:4];
    assign cmd_idx = cmd_ch[CHW-1:0];
    assign cmd_bad = ({1'b0, cmd_ch} >= 5'(CHANNELS)) || (cmd_op > OP_ERRS);

    function automatic logic [FREE_WIDTH-1:0] pick_free(
        input logic [CHANNELS*FREE_WIDTH-1:0] vec,
        input logic [CHW-1:0]                 ch
    );
        logic [FREE_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch == CHW'(k)) r = vec[k*FREE_WIDTH +: FREE_WIDTH];
        end
        return r;
    endfunction

    // A count wider than the reply word saturates instead of wrapping.
    function automatic logic [WORD_SIZE-1:0] sat_word(input logic [FREE_WIDTH-1:0] f);
        logic [XW-1:0] e;
        e = XW'(f);
        if (e > XW'({WORD_SIZE{1'b1}})) return '1;
        return e[WORD_SIZE-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sel_n    = sel_ch;
        clear_n  = '0;
        flag_set = 3'b000;
        flag_clr = 1'b0;
        tx_load  = 1'b0;
        tx_errs  = 1'b0;
        buf_we   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!bus.cs) begin
                    state_n = S_CMD;
                    tx_load = 1'b1;
                end
            end
            S_CMD: begin
                if (bus.cs) begin
                    state_n = S_IDLE;
                end else if (rx_v) begin
                    tx_load = 1'b1;
                    if (cmd_bad) begin
                        flag_set[2] = 1'b1;
                        state_n     = S_SINK;
                    end else begin
                        case (cmd_op)
                            OP_STATUS: sel_n = cmd_idx;
                            OP_WRITE: begin
                                sel_n   = cmd_idx;
                                cnt_n   = '0;
                                state_n = S_COLLECT;
                            end
                            OP_CLEAR: clear_n[cmd_idx] = 1'b1;
                            OP_ERRS: begin
                                tx_errs  = 1'b1;
                                flag_clr = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_COLLECT: begin
                if (bus.cs) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (rx_v) begin
                    tx_load = 1'b1;
                    buf_we  = 1'b1;
                    if (cnt == LAST) begin
                        cnt_n = '0;
                        if (pick_free(bus.fifo_free, sel_ch) != '0) state_n = S_DRAIN;
                        else flag_set[0] = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_v) begin
                    tx_load     = 1'b1;
                    flag_set[1] = 1'b1;
                end
                // cs is only looked at once the burst is complete.
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = bus.cs ? S_IDLE : S_COLLECT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SINK: begin
                if (bus.cs) state_n = S_IDLE;
                else if (rx_v) tx_load = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sel_ch  <= '0;
            flags   <= 3'b000;
            clear_q <= '0;
            tx_q    <= '0;
            for (int i = 0; i < RECORD_WORDS; i++) rec_buf[i] <= '0;
        end else begin
            cnt     <= cnt_n;
            sel_ch  <= sel_n;
            clear_q <= clear_n;
            flags   <= (flag_clr ? 3'b000 : flags) | flag_set;
            if (tx_load) begin
                tx_q <= tx_errs ? WORD_SIZE'(flags) : sat_word(pick_free(bus.fifo_free, sel_n));
            end
            if (buf_we) rec_buf[cnt] <= bus.rx_word;
        end
    end

    always_comb begin
        bus.fifo_write_en = '0;
        bus.fifo_data     = '0;
        if (state == S_DRAIN) begin
            bus.fifo_write_en[sel_ch] = 1'b1;
            bus.fifo_data             = rec_buf[cnt];
        end
    end

    assign bus.tx_word    = tx_q;
    assign bus.fifo_clear = clear_q;
    assign bus.err_flags  = flags;
    assign bus.busy       = (state == S_COLLECT) || (state == S_DRAIN);
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_spi_command_frontend.sv
// Self-checking bench for spi_command_frontend (2 channels, 4-word records);
// a negedge monitor pops expected {channel, data} pairs for every FIFO write.
module tb_spi_command_frontend;
    localparam int WORD_SIZE    = 8;
    localparam int RECORD_WORDS = 4;
    localparam int CHANNELS     = 2;
    localparam int FREE_WIDTH   = 5;
    localparam int EW           = 1 + WORD_SIZE;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_SINK    = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got, mon_exp;

    spi_command_frontend_if #(.WORD_SIZE(WORD_SIZE), .CHANNELS(CHANNELS), .FREE_WIDTH(FREE_WIDTH)) bus ();

    spi_command_frontend #(
        .WORD_SIZE(WORD_SIZE), .RECORD_WORDS(RECORD_WORDS),
        .CHANNELS(CHANNELS), .FREE_WIDTH(FREE_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.fifo_write_en !== '0) begin
            checks++;
            mon_got = {bus.fifo_write_en[1], bus.fifo_data};
            if (!$onehot(bus.fifo_write_en)) begin
                errors++;
                $display("FAIL write_onehot: got %b required one-hot", bus.fifo_write_en);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got ch/data %h required no write", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL write_data: got ch/data %h required %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        bus.rx_word  = b;
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic send_record(input logic ch, input logic [31:0] words, input bit expect_write, input int last_gap);
        logic [7:0] b;
        for (int i = 0; i < RECORD_WORDS; i++) begin
            b = words[31-8*i -: 8];
            if (expect_write) exp_q.push_back({ch, b});
            send_byte(b, (i == RECORD_WORDS - 1) ? last_gap : 2);
        end
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        tick(1);
    endtask

    task automatic cs_high();
        @(posedge clk);
        #1;
        bus.cs = 1'b1;
        tick(2);
    endtask

    task automatic check_state(input string name, input logic [2:0] required);
        checks++;
        if (bus.state_dbg !== required) begin
            errors++;
            $display("FAIL %s: got state %0d required %0d", name, bus.state_dbg, required);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d writes outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({bus.fifo_write_en, bus.fifo_clear, bus.busy, bus.err_flags, bus.tx_word, bus.fifo_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b clr=%b busy=%b err=%b tx=%h data=%h required all 0",
                     bus.fifo_write_en, bus.fifo_clear, bus.busy, bus.err_flags, bus.tx_word, bus.fifo_data);
        end
        check_state("reset_state", ST_IDLE);
        rst_n = 1'b1;
        tick(2);
        check_state("idle_cs_high", ST_IDLE);
    endtask

    task automatic test_reset_mid_drain();
        bus.fifo_free = {5'd3, 5'd7};
        cs_low();
        send_byte(8'h02, 1);
        exp_q.push_back({1'b0, 8'hC1});
        exp_q.push_back({1'b0, 8'hC2});
        send_byte(8'hC1, 2);
        send_byte(8'hC2, 2);
        send_byte(8'hC3, 2);
        send_byte(8'hC4, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_write_en, bus.busy, bus.tx_word, bus.err_flags, bus.fifo_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain: got we=%b busy=%b tx=%h err=%b data=%h required all 0",
                     bus.fifo_write_en, bus.busy, bus.tx_word, bus.err_flags, bus.fifo_data);
        end
        tick(3);
        check_queue_empty("reset_drain_writes");
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (bus.tx_word !== 8'd7) begin
            errors++;
            $display("FAIL reset_release_tx: got %h required %h", bus.tx_word, 8'd7);
        end
        check_state("reset_release_state", ST_CMD);
        cs_high();
    endtask

    task automatic test_write_ch1();
        bus.fifo_free = {5'd3, 5'd0};
        cs_low();
        send_byte(8'h12, 1);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_write_cmd: got %b required 1", bus.busy);
        end
        send_record(1'b1, 32'hA1A2_A3A4, 1'b1, 0);
        bus.cs = 1'b1;
        for (int i = 0; i < RECORD_WORDS; i++) begin
            @(negedge clk);
            checks++;
            if (bus.fifo_write_en !== 2'b10 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL burst_cycle_%0d: got we=%b busy=%b required we=10 busy=1", i, bus.fifo_write_en, bus.busy);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.fifo_write_en !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: got we=%b busy=%b required we=00 busy=0", bus.fifo_write_en, bus.busy);
        end
        tick(1);
        check_state("drain_then_idle", ST_IDLE);
        check_queue_empty("write_ch1_writes");
    endtask

    task automatic test_full_drop();
        bus.fifo_free = {5'd3, 5'd0};
        cs_low();
        send_byte(8'h02, 1);
        send_record(1'b0, 32'hB1B2_B3B4, 1'b0, 3);
        checks++;
        if (bus.err_flags !== 3'b001) begin
            errors++;
            $display("FAIL full_drop_flag: got %b required 001", bus.err_flags);
        end
        check_state("full_drop_state", ST_COLLECT);
        cs_high();
        cs_low();
        send_byte(8'h04, 1);
        checks++;
        if (bus.tx_word !== 8'h01) begin
            errors++;
            $display("FAIL errs_reply: got %h required 01", bus.tx_word);
        end
        checks++;
        if (bus.err_flags !== 3'b000) begin
            errors++;
            $display("FAIL errs_cleared: got %b required 000", bus.err_flags);
        end
        cs_high();
        check_queue_empty("full_drop_writes");
    endtask

    task automatic test_abort();
        bus.fifo_free = {5'd3, 5'd9};
        cs_low();
        send_byte(8'h02, 1);
        send_byte(8'hBB, 2);
        send_byte(8'hBC, 2);
        cs_high();
        check_state("abort_idle", ST_IDLE);
        check_queue_empty("abort_no_write");
        cs_low();
        send_byte(8'h02, 1);
        send_record(1'b0, 32'hD1D2_D3D4, 1'b1, 6);
        check_queue_empty("after_abort_writes");
        checks++;
        if (bus.tx_word !== 8'd9) begin
            errors++;
            $display("FAIL default_tx: got %h required %h", bus.tx_word, 8'd9);
        end
        cs_high();
    endtask

    task automatic test_bad_cmd_clear();
        cs_low();
        send_byte(8'h23, 1);
        checks++;
        if (bus.err_flags !== 3'b100) begin
            errors++;
            $display("FAIL bad_channel_flag: got %b required 100", bus.err_flags);
        end
        check_state("bad_channel_sink", ST_SINK);
        send_byte(8'h02, 1);
        send_record(1'b0, 32'hE1E2_E3E4, 1'b0, 6);
        check_state("sink_holds", ST_SINK);
        check_queue_empty("sink_no_write");
        cs_high();
        cs_low();
        send_byte(8'h07, 1);
        checks++;
        if (bus.err_flags !== 3'b100 || bus.state_dbg !== ST_SINK) begin
            errors++;
            $display("FAIL bad_opcode: got err=%b state=%0d required err=100 state=4", bus.err_flags, bus.state_dbg);
        end
        cs_high();
        cs_low();
        send_byte(8'h04, 1);
        checks++;
        if (bus.tx_word !== 8'h04) begin
            errors++;
            $display("FAIL errs_bad_reply: got %h required 04", bus.tx_word);
        end
        for (int ch = 0; ch < CHANNELS; ch++) begin
            send_byte({4'(ch), 4'h3}, 0);
            @(negedge clk);
            checks++;
            if (bus.fifo_clear !== 2'(1 << ch)) begin
                errors++;
                $display("FAIL clear_pulse_ch%0d: got %b required %b", ch, bus.fifo_clear, 2'(1 << ch));
            end
            @(negedge clk);
            checks++;
            if (bus.fifo_clear !== 2'b00) begin
                errors++;
                $display("FAIL clear_single_ch%0d: got %b required 00", ch, bus.fifo_clear);
            end
        end
        cs_high();
    endtask

    task automatic test_status();
        logic [4:0] f0, f1;
        f0 = 5'($urandom_range(1, 31));
        f1 = 5'($urandom_range(1, 31));
        bus.fifo_free = {f1, f0};
        cs_low();
        send_byte(8'h11, 1);
        checks++;
        if (bus.tx_word !== 8'(f1)) begin
            errors++;
            $display("FAIL status_ch1: got %h required %h", bus.tx_word, 8'(f1));
        end
        send_byte(8'h01, 1);
        checks++;
        if (bus.tx_word !== 8'(f0)) begin
            errors++;
            $display("FAIL status_ch0: got %h required %h", bus.tx_word, 8'(f0));
        end
        cs_high();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, r1;
        r0 = $urandom;
        r1 = $urandom;
        bus.fifo_free = {5'd3, 5'd3};
        cs_low();
        send_byte(8'h02, 1);
        send_record(1'b0, r0, 1'b1, 0);
        send_byte(8'hEE, 0);
        tick(4);
        checks++;
        if (bus.err_flags !== 3'b010) begin
            errors++;
            $display("FAIL overrun_flag: got %b required 010", bus.err_flags);
        end
        check_state("stream_collect", ST_COLLECT);
        send_record(1'b0, r1, 1'b1, 6);
        check_queue_empty("stream_writes");
        cs_high();
    endtask

    initial begin
        bus.cs        = 1'b1;
        bus.rx_word   = '0;
        bus.rx_ready  = 1'b0;
        bus.fifo_free = '0;
        test_reset();
        test_reset_mid_drain();
        test_write_ch1();
        test_full_drop();
        test_abort();
        test_bad_cmd_clear();
        test_status();
        test_back_to_back();
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
